switch_debounce3: RTL and testbench

Three-channel mechanical switch conditioner that sits directly upstream of the lamp-control logic. It takes the raw, asynchronous, bouncing levels of the three lamp switches and produces clean, clock-synchronous levels on `S1`, `S2` and `S3` that drive the `S1/S2/S3` inputs of the lamp controller. It also emits a one-cycle change strobe per channel for logging or edge-driven consumers.

---
 rtl/switch_debounce3.sv | 87 ++++++++
 tb/tb_switch_debounce3.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce3.sv
// switch_debounce3: three independent synchronize-and-debounce channels for the lamp switches.
// Build option SW_DEBOUNCE_BYPASS_EN replaces the qualification counters with one register stage.
//
// state | meaning (implicit per channel, derived from sync vs out)
// IDLE  | sync == out, qualification counter held at 0
// CHK   | sync != out, counter qualifying the new level

module switch_debounce3 #(
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] SW_IN,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic [2:0] CHG
);

  logic [2:0] s0_q;
  logic [2:0] sync_q;
  logic [2:0] out_q;
  logic [2:0] out_d;
  logic [2:0] chg_q;
  logic [2:0] chg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= '0;
      sync_q <= '0;
      out_q  <= '0;
      chg_q  <= '0;
    end else begin
      s0_q   <= SW_IN;
      sync_q <= s0_q;
      out_q  <= out_d;
      chg_q  <= chg_d;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  always_comb begin
    out_d = sync_q;
    chg_d = sync_q ^ out_q;
  end
`else
  localparam int unsigned       CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_TC  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  logic [2:0][CW-1:0] cnt_q;
  logic [2:0][CW-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A sample matching the current output (IDLE) restarts the full window.
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          out_d[i] = sync_q[i];
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end
`endif

  always_comb begin
    S1  = out_q[0];
    S2  = out_q[1];
    S3  = out_q[2];
    CHG = chg_q;
  end

endmodule

// File: tb/tb_switch_debounce3.sv
// Bench for switch_debounce3 (STABLE_CYCLES=4): directed plan steps plus random switch activity,
// checked against a sliding-window model of the sampled switch history.

module tb_switch_debounce3;
  localparam int SC = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] SW_IN;
  logic       S1, S2, S3;
  logic [2:0] CHG;

  int n_cmp;
  int n_bad;

  logic [2:0] hist[$];
  logic [2:0] m_out;
  logic [2:0] m_chg;

  switch_debounce3 #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .SW_IN(SW_IN),
    .S1(S1), .S2(S2), .S3(S3), .CHG(CHG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    for (int k = 0; k < SC + 2; k++) hist.push_back(3'b000);
    m_out = 3'b000;
    m_chg = 3'b000;
  endfunction

  // Output follows a level once the last SC synchronizer-delayed samples all agree.
  function automatic void model_edge(input logic [2:0] sw);
    logic [2:0] prev;
    logic       same;
    hist.push_back(sw);
    hist.pop_front();
    prev = m_out;
`ifdef SW_DEBOUNCE_BYPASS_EN
    m_out = hist[hist.size() - 3];
`else
    for (int ch = 0; ch < 3; ch++) begin
      same = 1'b1;
      for (int k = 1; k < SC; k++)
        if (hist[k][ch] != hist[0][ch]) same = 1'b0;
      if (same) m_out[ch] = hist[0][ch];
    end
`endif
    m_chg = m_out ^ prev;
  endfunction

  // Starts and ends just after a falling edge.
  task automatic step(input logic [2:0] sw);
    SW_IN = sw;
    @(posedge clk);
    model_edge(sw);
    #1;
    chk("model_out", {S3, S2, S1}, m_out);
    chk("model_chg", CHG, m_chg);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_out_async", {S3, S2, S1}, 3'b000);
    chk("rst_chg_async", CHG, 3'b000);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_out_hold", {S3, S2, S1}, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] sw;
    int         pulses;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    SW_IN = 3'b111;
    model_clear();
    @(negedge clk);

    // Reset with switches high, then release and qualify 3'b111.
    do_reset(3);
    for (int e = 1; e <= 7; e++) begin
      step(3'b111);
`ifndef SW_DEBOUNCE_BYPASS_EN
      if (e == 5) chk("rel_before", {S3, S2, S1}, 3'b000);
      if (e == 6) begin
        chk("rel_rise", {S3, S2, S1}, 3'b111);
        chk("rel_chg", CHG, 3'b111);
      end
      if (e == 7) chk("rel_chg_once", CHG, 3'b000);
`endif
    end

    // Bounce on channel 0.
    do_reset(1);
    repeat (3) step(3'b000);
    step(3'b001); step(3'b000); step(3'b001); step(3'b000);
    pulses = 0;
    for (int e = 1; e <= 9; e++) begin
      step(3'b001);
      if (CHG[0]) pulses++;
`ifndef SW_DEBOUNCE_BYPASS_EN
      if (e == 5) chk("bounce_hold", {S3, S2, S1}, 3'b000);
      if (e == 6) begin
        chk("bounce_rise", {S3, S2, S1}, 3'b001);
        chk("bounce_chg", CHG, 3'b001);
      end
`endif
    end
`ifndef SW_DEBOUNCE_BYPASS_EN
    chk("bounce_pulses", 3'(pulses), 3'd1);
`endif

    // Glitch boundary on channel 1.
    do_reset(1);
    repeat (3) step(3'b000);
    pulses = 0;
    repeat (3) begin step(3'b010); if (CHG[1]) pulses++; end
    repeat (8) begin step(3'b000); if (CHG[1]) pulses++; end
`ifndef SW_DEBOUNCE_BYPASS_EN
    chk("glitch3_s2", {S3, S2, S1}, 3'b000);
    chk("glitch3_pulses", 3'(pulses), 3'd0);
`endif
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      step((e <= 4) ? 3'b010 : 3'b000);
      if (CHG[1]) pulses++;
`ifndef SW_DEBOUNCE_BYPASS_EN
      if (e == 6)  chk("glitch4_rise", {S3, S2, S1}, 3'b010);
      if (e == 10) chk("glitch4_fall", {S3, S2, S1}, 3'b000);
`endif
    end
`ifndef SW_DEBOUNCE_BYPASS_EN
    chk("glitch4_pulses", 3'(pulses), 3'd2);
`endif

    // Independence: channels 0 and 2 together.
    do_reset(1);
    repeat (3) step(3'b000);
    for (int e = 1; e <= 8; e++) begin
      step(3'b101);
`ifndef SW_DEBOUNCE_BYPASS_EN
      if (e == 6) begin
        chk("indep_rise", {S3, S2, S1}, 3'b101);
        chk("indep_chg", CHG, 3'b101);
      end
      if (e == 7) chk("indep_chg_once", CHG, 3'b000);
`endif
    end

    // Reset in the middle of a qualification on channel 2.
    do_reset(1);
    repeat (3) step(3'b000);
    repeat (4) step(3'b100);
    do_reset(1);
    for (int e = 1; e <= 7; e++) begin
      step(3'b100);
`ifndef SW_DEBOUNCE_BYPASS_EN
      if (e == 5) chk("midrst_hold", {S3, S2, S1}, 3'b000);
      if (e == 6) chk("midrst_rise", {S3, S2, S1}, 3'b100);
`endif
    end

`ifdef SW_DEBOUNCE_BYPASS_EN
    // One-cycle pulse passes straight through after three edges.
    do_reset(1);
    repeat (3) step(3'b000);
    pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      step((e == 1) ? 3'b001 : 3'b000);
      if (CHG[0]) pulses++;
      if (e == 2) chk("byp_before", {S3, S2, S1}, 3'b000);
      if (e == 3) chk("byp_high", {S3, S2, S1}, 3'b001);
      if (e == 4) chk("byp_low", {S3, S2, S1}, 3'b000);
    end
    chk("byp_pulses", 3'(pulses), 3'd2);
`endif

    // Random switch activity with occasional resets.
    do_reset(1);
    sw = 3'b000;
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 4) == 0) sw[ch] = ~sw[ch];
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
      step(sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
